// File: rtl/dtm_dmi_initiator_if.sv
// DMI request/response channel between the DTM initiator (master) and the debug module (slave).
// Signal names keep their direction suffixes as seen from the initiator.
interface dtm_dmi_initiator_if;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i;
    logic [40:0] dmi_req_o;
    logic        dmi_resp_valid_i;
    logic        dmi_resp_ready_o;
    logic [33:0] dmi_resp_i;

    modport master (
        output dmi_req_valid_o,
        input  dmi_req_ready_i,
        output dmi_req_o,
        input  dmi_resp_valid_i,
        output dmi_resp_ready_o,
        input  dmi_resp_i
    );

    modport slave (
        input  dmi_req_valid_o,
        output dmi_req_ready_i,
        input  dmi_req_o,
        output dmi_resp_valid_i,
        input  dmi_resp_ready_o,
        output dmi_resp_i
    );
endinterface

// File: rtl/dtm_dmi_initiator.sv
// JTAG DTM to DMI initiator: turns scanned words into DMI transactions with a sticky status.
// Optional request timeout is enabled by defining DTM_DMI_TIMEOUT_EN.
module dtm_dmi_initiator #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       update_i,
    input  logic [1:0]                 scan_op_i,
    input  logic [6:0]                 scan_addr_i,
    input  logic [31:0]                scan_data_i,
    input  logic                       dmireset_i,
    dtm_dmi_initiator_if.master        dmi,
    output logic [31:0]                capture_data_o,
    output logic [1:0]                 capture_op_o,
    output logic                       busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_e;

    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    localparam logic [1:0] OpRead   = 2'd1;
    localparam logic [1:0] OpWrite  = 2'd2;
    localparam logic [1:0] StFailed = 2'd2;
    localparam logic [1:0] StBusy   = 2'd3;

    if (TimeoutCycles == 0 || TimeoutCycles > 65535) begin : g_param_check
        $error("TimeoutCycles must be in 1..65535");
    end

    state_e    r_state;
    state_e    w_state_next;
    dmi_req_t  r_req;
    logic [31:0] r_capture_data;
    logic [1:0]  r_sticky;
    logic [1:0]  w_sticky_next;
    logic [1:0]  w_set_val;
    dmi_resp_t w_resp;
    logic      w_update_go;
    logic      w_req_hs;
    logic      w_resp_hs;
    logic      w_busy_set;
    logic      w_err_set;
    logic      w_timeout;

    assign w_resp      = dmi.dmi_resp_i;
    assign w_req_hs    = (r_state == ST_REQ)  && dmi.dmi_req_ready_i;
    assign w_resp_hs   = (r_state == ST_WAIT) && dmi.dmi_resp_valid_i;
    assign w_update_go = (r_state == ST_IDLE) && update_i && (r_sticky == 2'd0)
                         && ((scan_op_i == OpRead) || (scan_op_i == OpWrite));
    assign w_busy_set  = update_i && (r_state != ST_IDLE);
    assign w_err_set   = w_resp_hs && (w_resp.resp != 2'd0);

`ifdef DTM_DMI_TIMEOUT_EN
    localparam logic [15:0] LastCnt = 16'(TimeoutCycles - 1);

    logic [15:0] r_cnt;

    // Counter restarts as REQ is entered; a handshake in the last allowed cycle beats the timeout.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= 16'd0;
        end else if (w_update_go) begin
            r_cnt <= 16'd0;
        end else if (r_state != ST_IDLE) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_state != ST_IDLE) && (r_cnt >= LastCnt) && !w_req_hs && !w_resp_hs;
`else
    assign w_timeout = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next         = r_state;
        dmi.dmi_req_valid_o  = 1'b0;
        dmi.dmi_resp_ready_o = 1'b0;
        busy_o               = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (w_update_go) w_state_next = ST_REQ;
            end
            ST_REQ: begin
                dmi.dmi_req_valid_o = 1'b1;
                if (w_req_hs)       w_state_next = ST_WAIT;
                else if (w_timeout) w_state_next = ST_IDLE;
            end
            ST_WAIT: begin
                dmi.dmi_resp_ready_o = 1'b1;
                if (w_resp_hs || w_timeout) w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // A set event beats a simultaneous dmireset; otherwise the first nonzero status sticks.
    always_comb begin
        w_set_val = 2'd0;
        if (w_err_set || w_timeout) w_set_val = StFailed;
        else if (w_busy_set)        w_set_val = StBusy;

        w_sticky_next = r_sticky;
        if (dmireset_i) w_sticky_next = 2'd0;
        if ((w_set_val != 2'd0) && ((r_sticky == 2'd0) || dmireset_i)) begin
            w_sticky_next = w_set_val;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sticky       <= 2'd0;
            r_req          <= '0;
            r_capture_data <= 32'd0;
        end else begin
            r_sticky <= w_sticky_next;
            if (w_update_go) begin
                r_req.addr <= scan_addr_i;
                r_req.op   <= scan_op_i;
                r_req.data <= (scan_op_i == OpRead) ? 32'd0 : scan_data_i;
            end
            if (w_resp_hs && (r_req.op == OpRead)) begin
                r_capture_data <= w_resp.data;
            end
        end
    end

    assign dmi.dmi_req_o  = r_req;
    assign capture_data_o = r_capture_data;
    assign capture_op_o   = r_sticky;

endmodule

// File: tb/tb_dtm_dmi_initiator.sv
// Self-checking bench for dtm_dmi_initiator: request scoreboard, sticky-status model, reset and timeout cases.
module tb_dtm_dmi_initiator;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        update_i;
    logic [1:0]  scan_op_i;
    logic [6:0]  scan_addr_i;
    logic [31:0] scan_data_i;
    logic        dmireset_i;
    logic [31:0] capture_data_o;
    logic [1:0]  capture_op_o;
    logic        busy_o;

    dtm_dmi_initiator_if dmi ();

    dtm_dmi_initiator #(.TimeoutCycles(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .update_i       (update_i),
        .scan_op_i      (scan_op_i),
        .scan_addr_i    (scan_addr_i),
        .scan_data_i    (scan_data_i),
        .dmireset_i     (dmireset_i),
        .dmi            (dmi.master),
        .capture_data_o (capture_data_o),
        .capture_op_o   (capture_op_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int n_req = 0;
    logic [40:0] req_q[$];
    logic [31:0] exp_cap;
    logic [1:0]  exp_sticky;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumer: every cycle with valid high must present the queued word; a handshake pops it.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            chk("valid_ready_excl", dmi.dmi_req_valid_o && dmi.dmi_resp_ready_o, 1'b0);
            if (dmi.dmi_req_valid_o) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 1'b1, 1'b0);
                end else begin
                    chk("req_word", dmi.dmi_req_o, req_q[0]);
                    if (dmi.dmi_req_ready_i) begin
                        void'(req_q.pop_front());
                        n_req++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
        update_i    = 1'b1;
        scan_op_i   = op;
        scan_addr_i = addr;
        scan_data_i = data;
        tick();
        update_i    = 1'b0;
    endtask

    task automatic start_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                             input int rdy_dly);
        req_q.push_back({addr, op, (op == 2'd1) ? 32'd0 : data});
        issue(op, addr, data);
        chk("valid_at_n1", dmi.dmi_req_valid_o, 1'b1);
        repeat (rdy_dly) tick();
        dmi.dmi_req_ready_i = 1'b1;
        tick();
        dmi.dmi_req_ready_i = 1'b0;
        chk("resp_ready_in_wait", dmi.dmi_resp_ready_o, 1'b1);
    endtask

    task automatic finish_txn(input logic [1:0] op, input int rsp_dly,
                              input logic [31:0] rdata, input logic [1:0] rresp);
        repeat (rsp_dly) tick();
        dmi.dmi_resp_valid_i = 1'b1;
        dmi.dmi_resp_i       = {rdata, rresp};
        tick();
        dmi.dmi_resp_valid_i = 1'b0;
        dmi.dmi_resp_i       = '0;
        if (op == 2'd1) exp_cap = rdata;
        if (rresp != 2'd0 && exp_sticky == 2'd0) exp_sticky = 2'd2;
        chk("capture_data", capture_data_o, exp_cap);
        chk("capture_op", capture_op_o, exp_sticky);
        chk("busy_after_resp", busy_o, 1'b0);
    endtask

    task automatic pulse_dmireset();
        dmireset_i = 1'b1;
        tick();
        dmireset_i = 1'b0;
        exp_sticky = 2'd0;
        chk("dmireset_clears", capture_op_o, 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int req_before;
        rst_i                = 1'b1;
        update_i             = 1'b0;
        scan_op_i            = 2'd0;
        scan_addr_i          = 7'd0;
        scan_data_i          = 32'd0;
        dmireset_i           = 1'b0;
        dmi.dmi_req_ready_i  = 1'b0;
        dmi.dmi_resp_valid_i = 1'b0;
        dmi.dmi_resp_i       = '0;
        exp_cap              = 32'd0;
        exp_sticky           = 2'd0;
        repeat (3) tick();
        chk("rst_req_valid", dmi.dmi_req_valid_o, 1'b0);
        chk("rst_resp_ready", dmi.dmi_resp_ready_o, 1'b0);
        chk("rst_req_word", dmi.dmi_req_o, 41'd0);
        chk("rst_capture_data", capture_data_o, 32'd0);
        chk("rst_capture_op", capture_op_o, 2'd0);
        chk("rst_busy", busy_o, 1'b0);
        rst_i = 1'b0;
        tick();

        // Read 0x11: ready at N+1, response at N+3
        start_txn(2'd1, 7'h11, 32'hFFFF_FFFF, 0);
        finish_txn(2'd1, 1, 32'hDEAD_BEEF, 2'd0);

        // Write with ready low for 5 cycles; write leaves capture_data alone
        start_txn(2'd2, 7'h10, 32'h1, 5);
        finish_txn(2'd2, 0, 32'h1234_5678, 2'd0);

        // nop and reserved ops issue nothing
        issue(2'd0, 7'h05, 32'h0);
        chk("nop_idle", busy_o, 1'b0);
        issue(2'd3, 7'h06, 32'h0);
        chk("reserved_idle", busy_o, 1'b0);
        chk("reserved_no_valid", dmi.dmi_req_valid_o, 1'b0);

        // Update while in WAIT: busy sticky, word dropped, transaction continues
        req_before = n_req;
        start_txn(2'd1, 7'h20, 32'h0, 0);
        issue(2'd1, 7'h21, 32'h0);
        exp_sticky = 2'd3;
        chk("busy_sticky", capture_op_o, 2'd3);
        chk("still_waiting", dmi.dmi_resp_ready_o, 1'b1);
        finish_txn(2'd1, 0, 32'hCAFE_F00D, 2'd0);
        chk("one_request", n_req - req_before, 1);
        issue(2'd1, 7'h22, 32'h0);
        chk("sticky_blocks", busy_o, 1'b0);
        chk("sticky_kept", capture_op_o, 2'd3);
        pulse_dmireset();
        start_txn(2'd1, 7'h22, 32'h0, 1);
        finish_txn(2'd1, 2, 32'h0BAD_C0DE, 2'd0);

        // Error response sets 2; resp 3 also reads back as 2
        start_txn(2'd1, 7'h30, 32'h0, 0);
        finish_txn(2'd1, 0, 32'h5555_AAAA, 2'd2);
        issue(2'd2, 7'h31, 32'h9);
        chk("err_blocks", busy_o, 1'b0);
        chk("err_kept", capture_op_o, 2'd2);
        pulse_dmireset();
        start_txn(2'd2, 7'h32, 32'h77, 0);
        finish_txn(2'd2, 0, 32'h0, 2'd3);
        pulse_dmireset();

        // dmireset in the same cycle as a busy-setting update: set wins
        req_q.push_back({7'h40, 2'd2, 32'hA5A5_0001});
        issue(2'd2, 7'h40, 32'hA5A5_0001);
        dmireset_i = 1'b1;
        issue(2'd1, 7'h41, 32'h0);
        dmireset_i = 1'b0;
        exp_sticky = 2'd3;
        chk("set_beats_dmireset", capture_op_o, 2'd3);
        chk("dmireset_no_abort", dmi.dmi_req_valid_o, 1'b1);
        dmi.dmi_req_ready_i = 1'b1;
        tick();
        dmi.dmi_req_ready_i = 1'b0;
        finish_txn(2'd2, 0, 32'h0, 2'd0);
        pulse_dmireset();

        // Ready never asserted
`ifdef DTM_DMI_TIMEOUT_EN
        req_q.push_back({7'h50, 2'd1, 32'h0});
        issue(2'd1, 7'h50, 32'h0);
        repeat (3) tick();
        chk("valid_before_timeout", dmi.dmi_req_valid_o, 1'b1);
        tick();
        req_q.delete();
        chk("valid_after_timeout", dmi.dmi_req_valid_o, 1'b0);
        chk("timeout_idle", busy_o, 1'b0);
        chk("timeout_sticky", capture_op_o, 2'd2);
        exp_sticky = 2'd2;
        pulse_dmireset();
`else
        start_txn(2'd1, 7'h50, 32'h0, 1000);
        finish_txn(2'd1, 0, 32'h1357_9BDF, 2'd0);
`endif

        // Reset asserted in WAIT: outputs clear immediately, next read works
        start_txn(2'd1, 7'h60, 32'h0, 0);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_wait_valid", dmi.dmi_req_valid_o, 1'b0);
        chk("rst_wait_resp_ready", dmi.dmi_resp_ready_o, 1'b0);
        chk("rst_wait_req_word", dmi.dmi_req_o, 41'd0);
        chk("rst_wait_capture_data", capture_data_o, 32'd0);
        chk("rst_wait_capture_op", capture_op_o, 2'd0);
        chk("rst_wait_busy", busy_o, 1'b0);
        tick();
        rst_i = 1'b0;
        exp_cap    = 32'd0;
        exp_sticky = 2'd0;
        tick();
        start_txn(2'd1, 7'h61, 32'h0, 0);
        finish_txn(2'd1, 0, 32'h2468_ACE0, 2'd0);

        chk("scoreboard_empty", req_q.size(), 0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dtm_dmi_initiator.md
DTM_DMI_INITIATOR -- requirements
Module: dtm_dmi_initiator

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 255, meaning the number of cycles allowed in REQ plus WAIT before a request is abandoned; legal range is 1..65535.
REQ-002 SHALL have port clk_i, input, width 1: single clock; all state is clocked on its rising edge.
REQ-003 SHALL have port rst_i, input, width 1: reset, asynchronous and active-high.
REQ-004 SHALL have port update_i, input, width 1: one-cycle pulse indicating a new scan word.
REQ-005 SHALL have port scan_op_i, input, width 2: operation code (0 nop, 1 read, 2 write, 3 reserved).
REQ-006 SHALL have port scan_addr_i, input, width 7: DMI register address.
REQ-007 SHALL have port scan_data_i, input, width 32: write data.
REQ-008 SHALL have port dmireset_i, input, width 1: pulse that clears the sticky status.
REQ-009 SHALL have port dmi_req_valid_o, output, width 1: DMI request valid.
REQ-010 SHALL have port dmi_req_ready_i, input, width 1: DMI request ready.
REQ-011 SHALL have port dmi_req_o, output, width 41: dmi_req_t, made up of addr[6:0], op[1:0] and data[31:0].
REQ-012 SHALL have port dmi_resp_valid_i, input, width 1: DMI response valid.
REQ-013 SHALL have port dmi_resp_ready_o, output, width 1: DMI response ready.
REQ-014 SHALL have port dmi_resp_i, input, width 34: dmi_resp_t, made up of data[31:0] and resp[1:0].
REQ-015 SHALL have port capture_data_o, output, width 32: last read data.
REQ-016 SHALL have port capture_op_o, output, width 2: status (0 success, 2 failed, 3 busy).
REQ-017 SHALL have port busy_o, output, width 1: high whenever the FSM is not in IDLE.

Function
REQ-018 SHALL implement a three-state FSM with states IDLE, REQ and WAIT.
REQ-019 In IDLE, update_i with scan_op_i of 1 or 2 and the sticky status equal to 0 SHALL latch addr, op and data and enter REQ on the next cycle, so dmi_req_valid_o is high at N+1 for update_i at cycle N.
REQ-020 update_i with scan_op_i of 0 or 3 SHALL issue no request and leave the state unchanged.
REQ-021 update_i while the sticky status is nonzero SHALL issue no request, and the sticky value SHALL be preserved.
REQ-022 update_i in REQ or WAIT SHALL set the sticky status to 3 (busy) if it is 0, and SHALL drop the new word while the in-flight transaction continues.
REQ-023 In REQ, dmi_req_valid_o SHALL be 1 and dmi_req_o SHALL be held stable until dmi_req_ready_i; a cycle with both high SHALL move the FSM to WAIT.
REQ-024 dmi_req_o.data SHALL be driven to 0 for reads.
REQ-025 In WAIT, dmi_resp_ready_o SHALL be 1, and dmi_resp_ready_o SHALL be 0 in every other state.
REQ-026 A response handshake in WAIT SHALL return the FSM to IDLE on the next cycle.
REQ-027 A response handshake to a read SHALL update capture_data_o one cycle after the handshake, and a response to a write SHALL leave capture_data_o unchanged.
REQ-028 A response with resp not equal to 0 SHALL set the sticky status to 2 if it is 0; resp 3 is also reported as 2.
REQ-029 dmireset_i SHALL clear the sticky status to 0; if a set event occurs in the same cycle, the set SHALL win.
REQ-030 capture_op_o SHALL equal the sticky status.
REQ-031 dmireset_i SHALL NOT abort an in-flight transaction.
REQ-032 dmi_req_valid_o and dmi_resp_ready_o SHALL never be high simultaneously.

Reset
REQ-033 rst_i SHALL immediately force the following values: FSM to IDLE, dmi_req_valid_o 0, dmi_resp_ready_o 0, dmi_req_o 0, capture_data_o 0, capture_op_o 0, busy_o 0, and the timeout counter 0.
REQ-034 rst_i asserted mid-transaction SHALL abandon the transaction without generating a response or setting the sticky status.

Configuration
REQ-035 With macro DTM_DMI_TIMEOUT_EN defined, a counter SHALL clear on entry to REQ and increment each cycle spent in REQ or WAIT.
REQ-036 With DTM_DMI_TIMEOUT_EN defined, when the counter reaches TimeoutCycles the FSM SHALL deassert valid/ready, return to IDLE on the next cycle, and set the sticky status to 2.
REQ-037 With DTM_DMI_TIMEOUT_EN defined, a handshake in the same cycle the counter reaches TimeoutCycles SHALL win over the timeout.
REQ-038 Without DTM_DMI_TIMEOUT_EN, no counter SHALL exist and the FSM SHALL wait indefinitely in REQ and WAIT.

Verification
REQ-039 Read of address 0x11 with ready at N+1 and response {0xDEADBEEF, 0} at N+3 -> capture_data_o is 0xDEADBEEF, capture_op_o is 0, and busy_o is 0 at N+4.
REQ-040 Write of data 0x1 to address 0x10 with ready held low for 5 cycles -> dmi_req_o is stable for all 5 cycles and op is 2 at the handshake.
REQ-041 Second update_i while in WAIT -> capture_op_o is 3, exactly one request is issued, a following update_i is ignored, and after dmireset_i the next read is issued.
REQ-042 Response resp of 2 -> capture_op_o is 2; dmireset_i in the same cycle as a busy-setting update_i -> capture_op_o is 3.
REQ-043 With DTM_DMI_TIMEOUT_EN defined, TimeoutCycles of 4 and ready never asserted -> valid drops after 4 cycles and capture_op_o is 2; without the macro, valid is still high after 1000 cycles.
REQ-044 rst_i asserted in WAIT -> all outputs are 0 in the same cycle, and after release the next read completes normally.
